// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, optional
//   write-to-read bypass, optional hardwired zero register and a per-register busy
//   scoreboard for read-after-write hazard detection.
// Latency: reads combinational (0 cycles); writes and busy updates take effect on the next rising edge.
// Backpressure: none; every write and issue presented on an edge is accepted.
// Ports: clk/rst_n (async active-low); wen/wad/wdin x2 (port 1 wins on collision);
//   rad/rdout/rbusy packed per read port; iss_valid/iss_addr mark a pending write;
//   busy_vec is the registered scoreboard.
module regfile_mp #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wen0,
   input  logic [ADDR_WIDTH-1:0]        wad0,
   input  logic [DATA_WIDTH-1:0]        wdin0,
   input  logic                         wen1,
   input  logic [ADDR_WIDTH-1:0]        wad1,
   input  logic [DATA_WIDTH-1:0]        wdin1,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rad,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdout,
   output logic [NUM_RD-1:0]            rbusy,
   input  logic                         iss_valid,
   input  logic [ADDR_WIDTH-1:0]        iss_addr,
   output logic [2**ADDR_WIDTH-1:0]     busy_vec
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;

   // Writes and issues aimed at a hardwired zero register are dropped here,
   // so neither the array nor the scoreboard ever sees them.
   logic wr0_ok, wr1_ok, iss_ok;
   assign wr0_ok = wen0 && !((ZERO_REG != 0) && (wad0 == '0));
   assign wr1_ok = wen1 && !((ZERO_REG != 0) && (wad1 == '0));
   assign iss_ok = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wr0_ok) mem_q[wad0] <= wdin0;
         if (wr1_ok) mem_q[wad1] <= wdin1;
      end
   end

   // Issue beats write-back: an instruction issued against a register in the
   // same cycle its previous producer retires must still see it as pending.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (iss_ok && (iss_addr == ADDR_WIDTH'(i))) begin
            busy_d[i] = 1'b1;
         end else if ((wr0_ok && (wad0 == ADDR_WIDTH'(i))) ||
                      (wr1_ok && (wad1 == ADDR_WIDTH'(i)))) begin
            busy_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy_vec = busy_q;

   // Read ports. The stored path is already zero during reset; the bypass is
   // additionally gated by rst_n so live write data cannot leak out then.
   logic [ADDR_WIDTH-1:0] ra;
   logic [DATA_WIDTH-1:0] rd;
   logic                  bsy;
   logic                  hit0, hit1, hit_iss;

   always_comb begin
      rdout   = '0;
      rbusy   = '0;
      ra      = '0;
      rd      = '0;
      bsy     = 1'b0;
      hit0    = 1'b0;
      hit1    = 1'b0;
      hit_iss = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra      = rad[k*ADDR_WIDTH +: ADDR_WIDTH];
         rd      = mem_q[ra];
         bsy     = busy_q[ra];
         hit0    = wen0 && (wad0 == ra);
         hit1    = wen1 && (wad1 == ra);
         hit_iss = iss_valid && (iss_addr == ra);
         if ((BYPASS != 0) && rst_n) begin
            if (hit1) begin
               rd = wdin1;
            end else if (hit0) begin
               rd = wdin0;
            end
            // A retiring write clears the hazard early unless a new issue re-arms it.
            if ((hit0 || hit1) && !hit_iss) begin
               bsy = 1'b0;
            end
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd  = '0;
            bsy = 1'b0;
         end
         rdout[k*DATA_WIDTH +: DATA_WIDTH] = rd;
         rbusy[k]                          = bsy;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wen0 = 1'b0, wen1 = 1'b0, iss_valid = 1'b0;
   logic [3:0]  wad0 = '0, wad1 = '0, iss_addr = '0;
   logic [7:0]  wdin0 = '0, wdin1 = '0;
   logic [15:0] rad = '0;
   logic [31:0] rdout;
   logic [3:0]  rbusy;
   logic [15:0] busy_vec;
   logic [7:0]  b_rdout;
   logic [0:0]  b_rbusy;
   logic [15:0] b_busy_vec;

   always #5 clk = ~clk;

   // A: 4 read ports, bypass, zero register.
   regfile_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .wen0(wen0), .wad0(wad0), .wdin0(wdin0),
      .wen1(wen1), .wad1(wad1), .wdin1(wdin1),
      .rad(rad), .rdout(rdout), .rbusy(rbusy),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(busy_vec)
   );

   // B: single read port, no bypass, r0 is an ordinary register.
   regfile_mp #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_RD(1), .BYPASS(0), .ZERO_REG(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .wen0(wen0), .wad0(wad0), .wdin0(wdin0),
      .wen1(wen1), .wad1(wad1), .wdin1(wdin1),
      .rad(rad[3:0]), .rdout(b_rdout), .rbusy(b_rbusy),
      .iss_valid(iss_valid), .iss_addr(iss_addr), .busy_vec(b_busy_vec)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   // Reference model state.
   logic [7:0]  ma [16];
   logic [7:0]  mb [16];
   logic [15:0] ba, bb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic idle();
      wen0 = 1'b0; wen1 = 1'b0; iss_valid = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      ba = '0;
      bb = '0;
   endtask

   // One clock: predict outputs for the driven inputs, sample mid-cycle,
   // then advance the model at the rising edge.
   task automatic cycle();
      logic [3:0] a;
      logic [7:0] v;
      logic       b;
      logic [3:0] rb;
      if (!rst_n) model_clear();
      rb = '0;
      for (int k = 0; k < 4; k++) begin
         a = rad[k*4 +: 4];
         v = ma[a];
         b = ba[a];
         if (wen1 && wad1 == a) v = wdin1;
         else if (wen0 && wad0 == a) v = wdin0;
         if (((wen0 && wad0 == a) || (wen1 && wad1 == a)) && !(iss_valid && iss_addr == a)) b = 1'b0;
         if (a == 4'd0) begin v = '0; b = 1'b0; end
         if (!rst_n) begin v = '0; b = 1'b0; end
         push($sformatf("a_rdout%0d", k), {24'd0, v});
         rb[k] = b;
      end
      push("a_rbusy", {28'd0, rb});
      push("a_busy_vec", {16'd0, ba});
      push("b_rdout", {24'd0, mb[rad[3:0]]});
      push("b_rbusy", {31'd0, bb[rad[3:0]]});
      push("b_busy_vec", {16'd0, bb});

      #3;
      chk(tag_q.pop_front(), {24'd0, rdout[7:0]},   exp_q.pop_front());
      chk(tag_q.pop_front(), {24'd0, rdout[15:8]},  exp_q.pop_front());
      chk(tag_q.pop_front(), {24'd0, rdout[23:16]}, exp_q.pop_front());
      chk(tag_q.pop_front(), {24'd0, rdout[31:24]}, exp_q.pop_front());
      chk(tag_q.pop_front(), {28'd0, rbusy},        exp_q.pop_front());
      chk(tag_q.pop_front(), {16'd0, busy_vec},     exp_q.pop_front());
      chk(tag_q.pop_front(), {24'd0, b_rdout},      exp_q.pop_front());
      chk(tag_q.pop_front(), {31'd0, b_rbusy},      exp_q.pop_front());
      chk(tag_q.pop_front(), {16'd0, b_busy_vec},   exp_q.pop_front());

      @(posedge clk);
      if (rst_n) begin
         for (int i = 0; i < 16; i++) begin
            if (iss_valid && iss_addr == 4'(i) && i != 0) ba[i] = 1'b1;
            else if ((wen0 && wad0 == 4'(i)) || (wen1 && wad1 == 4'(i))) ba[i] = 1'b0;
            if (iss_valid && iss_addr == 4'(i)) bb[i] = 1'b1;
            else if ((wen0 && wad0 == 4'(i)) || (wen1 && wad1 == 4'(i))) bb[i] = 1'b0;
         end
         if (wen0 && wad0 != 4'd0) ma[wad0] = wdin0;
         if (wen1 && wad1 != 4'd0) ma[wad1] = wdin1;
         if (wen0) mb[wad0] = wdin0;
         if (wen1) mb[wad1] = wdin1;
      end
      #1;
   endtask

   task automatic wr(input int port, input logic [3:0] ad, input logic [7:0] d);
      if (port == 0) begin wen0 = 1'b1; wad0 = ad; wdin0 = d; end
      else           begin wen1 = 1'b1; wad1 = ad; wdin1 = d; end
   endtask

   initial begin
      model_clear();
      @(posedge clk);
      #1;
      // Reset state.
      rad = 16'h3210;
      cycle();
      rst_n = 1'b1;

      // Write r3 then pulse reset between edges with a write still presented.
      wr(0, 4'd3, 8'hA5); rad = 16'h0003; cycle();
      idle(); cycle();
      rst_n = 1'b0; wr(1, 4'd3, 8'h77); iss_valid = 1'b1; iss_addr = 4'd3; cycle();
      idle(); rst_n = 1'b1; cycle();

      // Collision on r5 (port 1 wins), then distinct addresses.
      wr(0, 4'd5, 8'h11); wr(1, 4'd5, 8'h22); rad = 16'h0005; cycle();
      idle(); cycle();
      wr(0, 4'd6, 8'h33); wr(1, 4'd7, 8'h44); rad = 16'h5076; cycle();
      idle(); rad = 16'h5567; cycle();

      // Bypass on r4: A sees new data before the edge, B after.
      wr(1, 4'd4, 8'h5C); rad = 16'h0004; cycle();
      idle(); cycle();

      // Zero register: write and issue r0.
      wr(0, 4'd0, 8'hFF); iss_valid = 1'b1; iss_addr = 4'd0; rad = 16'h0000; cycle();
      idle(); cycle();

      // Scoreboard on r9.
      rad = 16'h0090; iss_valid = 1'b1; iss_addr = 4'd9; cycle();
      idle(); rad = 16'h0099; cycle();
      wr(0, 4'd9, 8'hAB); cycle();
      idle(); cycle();
      wr(1, 4'd9, 8'hCD); iss_valid = 1'b1; iss_addr = 4'd9; cycle();
      idle(); cycle();
      wr(0, 4'd9, 8'hEE); cycle();
      idle(); cycle();

      // Random traffic over all four read ports.
      for (int n = 0; n < 300; n++) begin
         wen0      = 1'($urandom_range(0, 1));
         wen1      = 1'($urandom_range(0, 1));
         iss_valid = ($urandom_range(0, 3) == 0);
         wad0      = 4'($urandom);
         wad1      = 4'($urandom);
         wdin0     = 8'($urandom);
         wdin1     = 8'($urandom);
         iss_addr  = 4'($urandom);
         if ($urandom_range(0, 3) == 0) rad = {4{4'($urandom)}};
         else rad = 16'($urandom);
         cycle();
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
